// File: rtl/imm_packer_if.sv
// Stream bundle for imm_packer: decoded-field input stream and packed-word output stream.
// The master side is the field source plus the instruction-memory loader; the slave side is the packer.
interface imm_packer_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [63:0]       in_imm;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_last
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_last
    );
endinterface

// File: rtl/imm_packer.sv
// Packs decoded ld/sd/beq fields into RV64 instruction words on an addressed valid/ready stream.
// Define IMM_PACKER_RANGE_CHECK_EN to drop items whose immediate does not fit 12 signed bits.
module imm_packer #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    imm_packer_if.slave         bus,
    output logic                err,
    output logic [7:0]          err_count,
    output logic                done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic              out_valid_reg, out_valid_next;
    logic [31:0]       out_instr_reg, out_instr_next;
    logic              out_last_reg, out_last_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              last_seen_reg, last_seen_next;
    logic              err_reg, err_next;
    logic [7:0]        err_count_reg, err_count_next;

    logic              in_ready;
    logic              accept;
    logic              drop;
    logic              out_fire;
    logic              start_ok;
    logic              range_ok;
    logic [31:0]       packed_word;
    logic              unused_imm;

`ifdef IMM_PACKER_RANGE_CHECK_EN
    // Upper bits must be a pure sign extension of bit 11.
    assign range_ok = (&bus.in_imm[63:11]) | ~(|bus.in_imm[63:11]);
`else
    assign range_ok = 1'b1;
`endif
    assign unused_imm = ^bus.in_imm[63:12];

    always_comb begin
        packed_word = '0;
        case (bus.in_op)
            2'b00: packed_word = {bus.in_imm[11:0], bus.in_rs1, 3'b011, bus.in_rd, 7'b0000011};
            2'b01: packed_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b011,
                                  bus.in_imm[4:0], 7'b0100011};
            2'b11: packed_word = {bus.in_imm[11], bus.in_imm[9:4], bus.in_rs2, bus.in_rs1, 3'b000,
                                  bus.in_imm[3:0], bus.in_imm[10], 7'b1100011};
            default: packed_word = '0;
        endcase
    end

    // A new item may enter while the held word leaves in the same cycle.
    assign in_ready = (state_reg == S_RUN) && !last_seen_reg && (!out_valid_reg || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign drop     = accept && ((bus.in_op == 2'b10) || !range_ok);
    assign out_fire = out_valid_reg && bus.out_ready;
    assign start_ok = start && (state_reg != S_RUN);

    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        out_instr_next = out_instr_reg;
        out_last_next  = out_last_reg;
        addr_next      = addr_reg;
        last_seen_next = last_seen_reg;
        err_count_next = err_count_reg;
        err_next       = drop;

        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if ((out_fire && out_last_reg) || (drop && bus.in_last)) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase

        if (start_ok) begin
            addr_next      = ADDR_W'(BASE_ADDR);
            err_count_next = '0;
            last_seen_next = 1'b0;
        end else begin
            if (out_fire) addr_next = addr_reg + ADDR_W'(4);
            if (accept && bus.in_last) last_seen_next = 1'b1;
            if (drop && (err_count_reg != 8'hFF)) err_count_next = err_count_reg + 8'd1;
        end

        if (accept && !drop) begin
            out_valid_next = 1'b1;
            out_instr_next = packed_word;
            out_last_next  = bus.in_last;
        end else if (out_fire) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            out_instr_reg <= '0;
            out_last_reg  <= 1'b0;
            addr_reg      <= ADDR_W'(BASE_ADDR);
            last_seen_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            out_instr_reg <= out_instr_next;
            out_last_reg  <= out_last_next;
            addr_reg      <= addr_next;
            last_seen_reg <= last_seen_next;
            err_reg       <= err_next;
            err_count_reg <= err_count_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_instr = out_instr_reg;
    assign bus.out_addr  = addr_reg;
    assign bus.out_last  = out_last_reg;
    assign err           = err_reg;
    assign err_count     = err_count_reg;
    assign done          = (state_reg == S_DONE);
endmodule

// File: tb/tb_imm_packer.sv
// Scoreboard bench for imm_packer: stimulus pushes expected words, a negedge monitor pops on each handshake.
module tb_imm_packer;
    localparam int ADDR_W = 10;
`ifdef IMM_PACKER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic err;
    logic [7:0] err_count;
    logic done;

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    int exp_err_cnt = 0;
    int waited;
    logic [ADDR_W-1:0] held_addr;

    imm_packer_if #(.ADDR_W(ADDR_W)) bus ();

    imm_packer #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .err       (err),
        .err_count (err_count),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge whenever both are high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(bus.out_instr), 64'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_instr", 64'(bus.out_instr), 64'(e.instr));
                check("out_addr", 64'(bus.out_addr), 64'(e.addr));
                check("out_last", 64'(bus.out_last), 64'(e.last));
                $display("word 0x%08h @%0d last=%0b", bus.out_instr, bus.out_addr, bus.out_last);
            end
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cycle(1);
        start = 1'b0;
        exp_addr = '0;
        exp_err_cnt = 0;
        check("start_addr", 64'(bus.out_addr), 64'd0);
        check("start_errcnt", 64'(err_count), 64'd0);
        check("start_done", 64'(done), 64'd0);
    endtask

    // Entered and left at posedge+1; presents one item and waits (bounded) for acceptance.
    task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [63:0] imm, input logic last,
                        input logic [31:0] instr, input logic drop, output int nwait);
        exp_t e;
        bit ok;
        ok = 1'b0;
        nwait = 0;
        bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_imm = imm; bus.in_last = last; bus.in_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                if (!drop) begin
                    e.instr = instr; e.addr = exp_addr; e.last = last;
                    sb.push_back(e);
                    exp_addr = exp_addr + ADDR_W'(4);
                end else if (exp_err_cnt < 255) begin
                    exp_err_cnt++;
                end
            end else begin
                nwait++;
            end
            cycle(1);
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        else begin
            check("err_pulse", 64'(err), 64'(drop));
            check("err_count", 64'(err_count), 64'(exp_err_cnt));
            $display("item op=%0b imm=0x%0h drop=%0b waited=%0d", op, imm, drop, nwait);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.in_op = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
        bus.in_imm = 0; bus.in_last = 0; bus.out_ready = 1'b1;
        cycle(1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check("rst_out_addr", 64'(bus.out_addr), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        cycle(1);
        rst_n = 1'b1;
        cycle(1);
        check("idle_in_ready", 64'(bus.in_ready), 64'd0);
        start_pulse();

        send(2'b00, 5'd5, 5'd2, 5'd0, 64'd8, 1'b0, 32'h00813283, 1'b0, waited);
        send(2'b01, 5'd0, 5'd2, 5'd6, -64'sd8, 1'b0, 32'hFE613C23, 1'b0, waited);
        send(2'b11, 5'd0, 5'd1, 5'd2, 64'd4, 1'b0, 32'h00208463, 1'b0, waited);
        check("back_to_back_wait", 64'(waited), 64'd0);
        cycle(1);

        // Backpressure: first word must hold while the second waits.
        bus.out_ready = 1'b0;
        held_addr = exp_addr;
        send(2'b00, 5'd1, 5'd3, 5'd0, -64'sd1, 1'b0, 32'hFFF1B083, 1'b0, waited);
        bus.in_op = 2'b01; bus.in_rs1 = 5'd4; bus.in_rs2 = 5'd7; bus.in_imm = 64'd20;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_instr", 64'(bus.out_instr), 64'hFFF1B083);
            check("stall_addr", 64'(bus.out_addr), 64'(held_addr));
            cycle(1);
        end
        bus.out_ready = 1'b1;
        send(2'b01, 5'd0, 5'd4, 5'd7, 64'd20, 1'b0, 32'h00723A23, 1'b0, waited);

        send(2'b00, 5'd5, 5'd2, 5'd0, 64'd2048, 1'b0, 32'h80013283, RC, waited);
        cycle(1);
        check("range_addr", 64'(bus.out_addr), 64'(exp_addr));

        send(2'b10, 5'd1, 5'd1, 5'd1, 64'd0, 1'b1, 32'h0, 1'b1, waited);
        check("illegal_last_done", 64'(done), 64'd1);
        check("done_in_ready", 64'(bus.in_ready), 64'd0);
        cycle(1);
        check("err_single_pulse", 64'(err), 64'd0);
        start_pulse();

        // 256 words exactly wrap the 10-bit byte address back to zero.
        for (int i = 0; i < 256; i++)
            send(2'b00, 5'd5, 5'd2, 5'd0, 64'd8, (i == 255), 32'h00813283, 1'b0, waited);
        cycle(1);
        check("wrap_done", 64'(done), 64'd1);
        check("wrap_addr", 64'(bus.out_addr), 64'(exp_addr));
        start_pulse();

        for (int i = 0; i < 256; i++)
            send(2'b10, 5'd0, 5'd0, 5'd0, 64'd0, (i == 255), 32'h0, 1'b1, waited);
        check("sat_err_count", 64'(err_count), 64'd255);
        check("sat_done", 64'(done), 64'd1);
        start_pulse();

        // Reset with a word pending discards it.
        bus.out_ready = 1'b0;
        send(2'b00, 5'd5, 5'd2, 5'd0, 64'd8, 1'b0, 32'h00813283, 1'b0, waited);
        check("pending_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_addr", 64'(bus.out_addr), 64'd0);
        check("async_rst_instr", 64'(bus.out_instr), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        sb.delete();
        exp_addr = '0;
        cycle(2);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_op = 2'b00; bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_in_ready", 64'(bus.in_ready), 64'd0);
            check("post_rst_valid", 64'(bus.out_valid), 64'd0);
            cycle(1);
        end
        bus.in_valid = 1'b0;
        cycle(2);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_packer.md
# imm_packer

Streaming instruction assembler for the RV64 datapath test flow. It is the inverse of the immediate generator: it takes decoded fields (op, registers, 64-bit signed immediate) and packs them into 32-bit ld/sd/beq instruction words. Immediate bits are scattered so the immediate generator recovers the same value. Packed words leave on a valid/ready stream with a sequential word address, feeding the instruction-memory loader.

## Interface
Parameters:
- ADDR_W, 10, width of the output byte address
- BASE_ADDR, 0, byte address of the first word after `start`

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; enters RUN from IDLE or DONE and reloads the address counter
- in_valid  in  1  input field set valid
- in_ready  out  1  packer accepts the input this cycle
- in_op  in  2  00=ld, 01=sd, 11=beq, 10=illegal
- in_rd  in  5  destination register (ld)
- in_rs1  in  5  base / first compare register
- in_rs2  in  5  store data / second compare register
- in_imm  in  64  signed immediate; byte offset for ld/sd, halfword offset for beq
- in_last  in  1  marks the final item of a program
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  downstream accepts the output
- out_instr  out  32  packed instruction
- out_addr  out  ADDR_W  byte address of out_instr
- out_last  out  1  this word is the last of the program
- err  out  1  one-cycle pulse: an input was dropped
- err_count  out  8  saturating count of dropped inputs since `start`
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN on `start`. DONE to RUN on `start`.
- RUN to DONE when the `in_last` item completes: its output handshake finishes, or it is dropped.
- `start` in RUN is ignored.
- Input handshake: `in_ready = (state==RUN) && !last_seen && (!out_valid || out_ready)`. `last_seen` is set when an `in_last` item is accepted and cleared on `start`.
- Field packing by op:
  - ld: {imm[11:0], rs1, 3'b011, rd, 7'b0000011}.
  - sd: {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011}.
  - beq: {imm[11], imm[9:4], rs2, rs1, 3'b000, imm[3:0], imm[10], 7'b1100011}.
- Round-trip property: decoding the packed word through the immediate generator yields sext(imm[11:0]).
- Drop conditions:
  - `in_op==10`: always dropped.
  - Out-of-range immediate: dropped only under the configuration macro.
- A dropped item:
  - produces no output and does not advance the address;
  - pulses `err` in the cycle after acceptance;
  - increments `err_count`, saturating at 255.
- Address counter:
  - loaded with BASE_ADDR on `start`;
  - incremented by 4 on each output handshake;
  - wraps modulo 2^ADDR_W.
- `start` clears `err_count` and `last_seen`.

## Timing
- Latency is one cycle: an item accepted at edge N appears on `out_*` after edge N, with out_valid high.
- While `out_valid && !out_ready`, `out_instr`, `out_addr` and `out_last` hold stable, and `in_ready` is low.
- Simultaneous output handshake and new input acceptance in the same cycle is a full-throughput handover: one word per cycle.
- `done` rises in the cycle after the completing event of the `in_last` item.
- Reset values (asynchronous, any cycle, including mid-stream):
  - state IDLE;
  - out_valid, in_ready, err, done, out_last = 0;
  - out_instr = 0, out_addr = BASE_ADDR, err_count = 0.
- A pending output word is discarded on reset.

## Configuration
- IMM_PACKER_RANGE_CHECK_EN defined:
  - ld/sd require in_imm[63:11] all equal to in_imm[11]; beq applies the same check on in_imm[63:11];
  - violating items are dropped with `err`.
- Not defined:
  - no range check; in_imm[11:0] is packed as-is and upper bits are ignored;
  - `err` fires only for illegal op.

## Test plan
- ld rd=5, rs1=2, imm=8 after `start` (BASE_ADDR=0) -> next cycle out_instr=0x00813283, out_addr=0.
- sd rs2=6, rs1=2, imm=-8, then beq rs1=1, rs2=2, imm=4 back-to-back with out_ready=1 -> 0xFE613C23 @0, then 0x00208463 @4, one word per cycle.
- out_ready held low for 3 cycles with the second item waiting -> first word stable, in_ready=0; accepted in order after release, no loss or duplicate.
- With IMM_PACKER_RANGE_CHECK_EN, ld imm=2048 -> no output, err pulse, err_count=1, address unchanged. Without the macro -> out_instr=0x80013283 for rd=5, rs1=2.
- in_op=10 with in_last=1 -> dropped, err=1, done=1 next cycle. Then `start` -> RUN, err_count=0, out_addr=BASE_ADDR.
- rst_n asserted while out_valid=1 -> out_valid=0 immediately, state IDLE; no output until `start`.
